// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel tone-detection path: power width,
// default scaling shift and the debounce state encoding.
package goertzel_pkg;

  localparam int GOERTZEL_POWER_W = 64;
  localparam int GOERTZEL_SHIFT   = 35;

  typedef enum logic [1:0] {
    OFF,
    PEND_ON,
    ON,
    PEND_OFF
  } det_state_t;

endpackage

// File: rtl/goertzel_power_scale.sv
// Combinational power scaling: right shift by SHIFT, then clamp to OUT_W bits
// with a flag raised whenever the clamp engaged.
module goertzel_power_scale
  import goertzel_pkg::*;
#(
  parameter int SHIFT = GOERTZEL_SHIFT,
  parameter int OUT_W = 32
) (
  input  logic [GOERTZEL_POWER_W-1:0] power,
  output logic [OUT_W-1:0]            power_scaled,
  output logic                        power_sat
);

  localparam logic [GOERTZEL_POWER_W-1:0] MAX_VAL =
    {{(GOERTZEL_POWER_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  function automatic logic [OUT_W:0] shift_sat(input logic [GOERTZEL_POWER_W-1:0] p);
    logic [GOERTZEL_POWER_W-1:0] s;
    s = p >> SHIFT;
    if (s > MAX_VAL) shift_sat = {1'b1, {OUT_W{1'b1}}};
    else             shift_sat = {1'b0, s[OUT_W-1:0]};
  endfunction

  assign {power_sat, power_scaled} = shift_sat(power);

endmodule

// File: rtl/goertzel_tone_detector.sv
// Captures each Goertzel block power on a ready rising edge, scales it, and
// debounces an on/off hysteresis comparison into a stable tone-present flag.
module goertzel_tone_detector
  import goertzel_pkg::*;
#(
  parameter int SHIFT     = GOERTZEL_SHIFT,
  parameter int OUT_W     = 32,
  parameter int ON_COUNT  = 3,
  parameter int OFF_COUNT = 3,
  parameter int CNT_W     = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ready,
  input  logic [GOERTZEL_POWER_W-1:0] power,
  input  logic [OUT_W-1:0]            thr_on,
  input  logic [OUT_W-1:0]            thr_off,
  output logic                        result_valid,
  output logic [OUT_W-1:0]            power_scaled,
  output logic                        power_sat,
  output logic                        detect,
  output logic                        detect_change,
  output logic [CNT_W-1:0]            block_count
);

  localparam int MAX_CNT = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int RUN_W   = $clog2(MAX_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] ON_LAST  = RUN_W'(ON_COUNT);
  localparam logic [RUN_W-1:0] OFF_LAST = RUN_W'(OFF_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             ready_d;
  logic             vld_p0;
  logic [OUT_W-1:0] scaled_p0;
  logic             sat_p0;

  logic             vld_p1;
  logic [OUT_W-1:0] scaled_p1;
  logic             sat_p1;
  logic [CNT_W-1:0] count_p1;

  det_state_t       state_p2, state_nxt;
  logic [RUN_W-1:0] run_p2, run_nxt, run_inc;
  logic             chg_p2, chg_nxt, det_nxt;
  logic             above, below;

  // ready_d resets high so a level already present at reset release is ignored
  assign vld_p0 = ready & ~ready_d;

  goertzel_power_scale #(
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_scale (
    .power        (power),
    .power_scaled (scaled_p0),
    .power_sat    (sat_p0)
  );

  // Stage 1: capture scaled result on the ready edge
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_d   <= 1'b1;
      vld_p1    <= 1'b0;
      scaled_p1 <= '0;
      sat_p1    <= 1'b0;
      count_p1  <= '0;
    end else begin
      ready_d <= ready;
      vld_p1  <= vld_p0;
      if (vld_p0) begin
        scaled_p1 <= scaled_p0;
        sat_p1    <= sat_p0;
        count_p1  <= count_p1 + CNT_ONE;
      end
    end
  end

  // Stage 2: hysteresis debounce, evaluated only on result cycles
  assign above   = scaled_p1 >= thr_on;
  assign below   = scaled_p1 <  thr_off;
  assign run_inc = run_p2 + RUN_ONE;

  always_comb begin
    state_nxt = state_p2;
    run_nxt   = run_p2;
    if (vld_p1) begin
      unique case (state_p2)
        OFF: if (above) begin
          if (ON_COUNT == 1) state_nxt = ON;
          else begin
            state_nxt = PEND_ON;
            run_nxt   = RUN_ONE;
          end
        end
        PEND_ON: if (above) begin
          if (run_inc == ON_LAST) begin
            state_nxt = ON;
            run_nxt   = '0;
          end else run_nxt = run_inc;
        end else begin
          state_nxt = OFF;
          run_nxt   = '0;
        end
        ON: if (below) begin
          if (OFF_COUNT == 1) state_nxt = OFF;
          else begin
            state_nxt = PEND_OFF;
            run_nxt   = RUN_ONE;
          end
        end
        PEND_OFF: if (below) begin
          if (run_inc == OFF_LAST) begin
            state_nxt = OFF;
            run_nxt   = '0;
          end else run_nxt = run_inc;
        end else begin
          state_nxt = ON;
          run_nxt   = '0;
        end
        default: begin
          state_nxt = OFF;
          run_nxt   = '0;
        end
      endcase
    end
    det_nxt = (state_nxt == ON) || (state_nxt == PEND_OFF);
    chg_nxt = det_nxt != detect;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_p2 <= OFF;
      run_p2   <= '0;
      chg_p2   <= 1'b0;
    end else begin
      state_p2 <= state_nxt;
      run_p2   <= run_nxt;
      chg_p2   <= chg_nxt;
    end
  end

  assign result_valid  = vld_p1;
  assign power_scaled  = scaled_p1;
  assign power_sat     = sat_p1;
  assign block_count   = count_p1;
  assign detect        = (state_p2 == ON) || (state_p2 == PEND_OFF);
  assign detect_change = chg_p2;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Scoreboard bench: two detector instances (SHIFT=35/CNT_W=4 and SHIFT=16/CNT_W=16)
// driven by the same stimulus and checked against a run-length hysteresis model.
module tb_goertzel_tone_detector;

  localparam int ON_N  = 3;
  localparam int OFF_N = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b1;
  logic [63:0] power = '0;
  logic [31:0] thr_on  = 32'd100;
  logic [31:0] thr_off = 32'd50;

  logic        rv_a, sat_a, det_a, chg_a;
  logic [31:0] ps_a;
  logic [3:0]  bc_a;
  logic        rv_b, sat_b, det_b, chg_b;
  logic [31:0] ps_b;
  logic [15:0] bc_b;

  always #5 clock = ~clock;

  goertzel_tone_detector #(.SHIFT(35), .OUT_W(32), .ON_COUNT(ON_N), .OFF_COUNT(OFF_N), .CNT_W(4)) dut_a (
    .clock(clock), .reset(reset), .ready(ready), .power(power), .thr_on(thr_on), .thr_off(thr_off),
    .result_valid(rv_a), .power_scaled(ps_a), .power_sat(sat_a), .detect(det_a),
    .detect_change(chg_a), .block_count(bc_a));

  goertzel_tone_detector #(.SHIFT(16), .OUT_W(32), .ON_COUNT(ON_N), .OFF_COUNT(OFF_N), .CNT_W(16)) dut_b (
    .clock(clock), .reset(reset), .ready(ready), .power(power), .thr_on(thr_on), .thr_off(thr_off),
    .result_valid(rv_b), .power_scaled(ps_b), .power_sat(sat_b), .detect(det_b),
    .detect_change(chg_b), .block_count(bc_b));

  typedef struct {
    logic [31:0] scaled;
    logic        sat;
    logic [15:0] cnt;
    logic        det;
    logic        chg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_run[2];
  bit   m_det[2];
  int   m_cnt[2];
  bit   pend[2], pdet[2], pchg[2], edet[2], echg[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scaled = clamp(power >> shift), detect toggles after N consecutive qualifying results.
  task automatic model_push(input logic [63:0] p);
    for (int i = 0; i < 2; i++) begin
      exp_t        e;
      logic [63:0] sh;
      logic        above, below;
      int          sft, wrap;
      sft  = (i == 0) ? 35 : 16;
      wrap = (i == 0) ? 16 : 65536;
      sh   = p >> sft;
      e.sat    = (sh > 64'h0000_0000_FFFF_FFFF);
      e.scaled = e.sat ? 32'hFFFF_FFFF : sh[31:0];
      m_cnt[i] = (m_cnt[i] + 1) % wrap;
      e.cnt    = 16'(m_cnt[i]);
      above = (e.scaled >= thr_on);
      below = (e.scaled <  thr_off);
      e.chg = 1'b0;
      if (!m_det[i]) begin
        if (above) begin
          m_run[i]++;
          if (m_run[i] == ON_N) begin m_det[i] = 1'b1; m_run[i] = 0; e.chg = 1'b1; end
        end else m_run[i] = 0;
      end else begin
        if (below) begin
          m_run[i]++;
          if (m_run[i] == OFF_N) begin m_det[i] = 1'b0; m_run[i] = 0; e.chg = 1'b1; end
        end else m_run[i] = 0;
      end
      e.det = m_det[i];
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic mon(input int i, input logic rv, input logic [31:0] ps, input logic sat,
                     input logic [15:0] bc, input logic det, input logic chg);
    exp_t  e;
    string tag;
    int    depth;
    tag = (i == 0) ? "a" : "b";
    if (pend[i]) begin
      edet[i] = pdet[i];
      echg[i] = pchg[i];
      pend[i] = 1'b0;
    end else echg[i] = 1'b0;
    if (rv) begin
      depth = (i == 0) ? qa.size() : qb.size();
      if (depth == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result_%s: result_valid=1 with no result outstanding at %0t", tag, $time);
      end else begin
        if (i == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk({"power_scaled_", tag}, 64'(ps), 64'(e.scaled));
        chk({"power_sat_", tag}, 64'(sat), 64'(e.sat));
        chk({"block_count_", tag}, 64'(bc), 64'(e.cnt));
        pend[i] = 1'b1;
        pdet[i] = e.det;
        pchg[i] = e.chg;
      end
    end
    chk({"detect_", tag}, 64'(det), 64'(edet[i]));
    chk({"detect_change_", tag}, 64'(chg), 64'(echg[i]));
  endtask

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        pend[i] = 1'b0; edet[i] = 1'b0; echg[i] = 1'b0;
      end
    end else begin
      mon(0, rv_a, ps_a, sat_a, {12'b0, bc_a}, det_a, chg_a);
      mon(1, rv_b, ps_b, sat_b, bc_b, det_b, chg_b);
    end
  end

  task automatic send(input logic [63:0] p, input int hold);
    @(posedge clock); #1;
    ready = 1'b0;
    @(posedge clock); #1;
    ready = 1'b1;
    power = p;
    model_push(p);
    repeat (hold - 1) @(posedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clock);
    chk("rst_result_valid_a", 64'(rv_a), 64'd0);
    chk("rst_power_scaled_a", 64'(ps_a), 64'd0);
    chk("rst_power_sat_a", 64'(sat_a), 64'd0);
    chk("rst_detect_a", 64'(det_a), 64'd0);
    chk("rst_detect_change_a", 64'(chg_a), 64'd0);
    chk("rst_block_count_a", 64'(bc_a), 64'd0);
    chk("rst_detect_b", 64'(det_b), 64'd0);
    chk("rst_block_count_b", 64'(bc_b), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    chk("outstanding_a", 64'(qa.size()), 64'd0);
    chk("outstanding_b", 64'(qb.size()), 64'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_det[i] = 1'b0; m_cnt[i] = 0;
    end
    check_reset_state();
  endtask

  initial begin
    int          seq_on[6]  = '{120, 120, 40, 120, 120, 120};
    int          seq_off[7] = '{60, 30, 30, 70, 30, 30, 30};
    logic [63:0] p, low;
    int          s;

    // Reset with ready held high: release must not count as a new result
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_reset_state();
    repeat (4) begin
      @(negedge clock);
      chk("no_edge_result_valid", 64'(rv_a), 64'd0);
      chk("no_edge_block_count", 64'(bc_a), 64'd0);
    end

    send(64'd5 << 35, 1);
    idle(4);

    foreach (seq_on[k]) send(64'(seq_on[k]) << 35, 1);
    idle(4);
    foreach (seq_off[k]) send((64'(seq_off[k]) << 35) | 64'd12345, 2);
    idle(4);

    send(64'h0001_0000_0000_0000, 1);
    send(64'h0000_0000_0001_0000, 1);
    idle(4);

    for (int r = 0; r < 4; r++) begin
      thr_on  = 32'($urandom_range(40, 200));
      thr_off = 32'($urandom_range(20, 220));
      for (int n = 0; n < 15; n++) begin
        s   = int'($urandom_range(0, 250));
        low = {$urandom, $urandom} & 64'h0000_0007_FFFF_FFFF;
        if ($urandom_range(0, 1) == 1) p = (64'(s) << 35) | low;
        else                           p = (64'(s) << 16) | (low & 64'hFFFF);
        send(p, int'($urandom_range(1, 3)));
      end
      idle(4);
    end

    thr_on  = 32'd100;
    thr_off = 32'd50;
    do_reset();
    for (int n = 0; n < 17; n++) send(64'(n) << 30, 1);
    idle(4);

    // Reset while in PEND_ON, then the run must restart from one
    send(64'd120 << 35, 1);
    idle(4);
    do_reset();
    for (int n = 0; n < 3; n++) send(64'd120 << 35, 1);
    idle(6);

    chk("final_outstanding_a", 64'(qa.size()), 64'd0);
    chk("final_outstanding_b", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
